// File: rtl/desc_stream_engine.sv
// rtl/desc_stream_engine.sv - walks an MPRF descriptor list and streams addressed words through a skid FIFO
// Optional feature macro: DESC_STREAM_ERR_EN (illegal opcodes raise sticky err and abort the list).
module desc_stream_engine #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 32,
  parameter int          RF_AW      = 5,
  parameter int          LEN_W      = 5,
  parameter int          OUT_DEPTH  = 2,
  parameter int          MEM_STRIDE = 4,
  parameter logic [15:0] DONE_OFF   = 16'h001F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RF_AW-1:0]  start_idx,
  input  logic [ADDR_W-1:0] start_out_addr,
  input  logic              pause,
  output logic              idle,
  output logic              rf_rd_en,
  output logic [RF_AW-1:0]  rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [CW:0]       DEPTH_C  = (CW+1)'(OUT_DEPTH);
  localparam logic [PW-1:0]     LAST_IDX = PW'(OUT_DEPTH - 1);
  localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(MEM_STRIDE);

  typedef enum logic [3:0] {
    S_IDLE, S_DFETCH, S_DDEC, S_LFETCH, S_LDEC, S_RFGATH, S_MEMREQ, S_MEMWAIT, S_DONE
  } state_t;

  state_t            state_q;
  logic [RF_AW-1:0]  ptr_q, src_q;
  logic [ADDR_W-1:0] run_addr_q, mem_addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic              is_mem_q, fresh_q, gath_q, req_hold_q, done_pushed_q, err_q, idle_q;

  logic [ADDR_W-1:0] fa_q [OUT_DEPTH];
  logic [DATA_W-1:0] fd_q [OUT_DEPTH];
  logic              fl_q [OUT_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     occ_q;

  logic [DATA_W-1:0] word;
  logic [2:0]        opc;
  logic              pop, credit, lit_push;
  logic              push, push_last;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  // Decode from the live read data on the first cycle, from the held copy while stalled.
  assign word      = fresh_q ? rf_rdata : hold_q;
  assign opc       = word[DATA_W-1 -: 3];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  // Room must exist for this word after everything already issued lands.
  assign credit    = ({1'b0, occ_q} + {{CW{1'b0}}, gath_q}) < (DEPTH_C + {{CW{1'b0}}, pop});
  assign lit_push  = (state_q == S_DDEC) && !pause && credit && (opc == 3'b000) && (word != '0);

  assign idle      = idle_q;
  assign mem_addr  = mem_addr_q;
  assign mem_req   = (state_q == S_MEMREQ) && (req_hold_q || (!pause && credit));
  assign out_addr  = out_valid ? fa_q[rd_q] : '0;
  assign out_data  = out_valid ? fd_q[rd_q] : '0;
  assign out_last  = out_valid ? fl_q[rd_q] : 1'b0;
`ifdef DESC_STREAM_ERR_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    rf_rd_en = 1'b0;
    rf_addr  = ptr_q;
    case (state_q)
      S_DFETCH, S_LFETCH: rf_rd_en = !pause;
      S_RFGATH: begin
        rf_rd_en = !pause && credit;
        rf_addr  = src_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_addr = run_addr_q;
    push_data = word;
    push_last = 1'b0;
    if (gath_q) begin
      push      = 1'b1;
      push_data = rf_rdata;
    end else if (state_q == S_MEMWAIT && mem_rvalid) begin
      push      = 1'b1;
      push_data = mem_rdata;
    end else if (lit_push) begin
      push = 1'b1;
    end else if (state_q == S_DONE && !pause && credit && !done_pushed_q && !err_q) begin
      push      = 1'b1;
      push_data = DATA_W'(1);
      push_last = 1'b1;
      push_addr = {run_addr_q[ADDR_W-1:16], DONE_OFF};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wr_q] <= push_addr;
      fd_q[wr_q] <= push_data;
      fl_q[wr_q] <= push_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) wr_q <= (wr_q == LAST_IDX) ? '0 : wr_q + PW'(1);
      if (pop)  rd_q <= (rd_q == LAST_IDX) ? '0 : rd_q + PW'(1);
      if (push && !pop)      occ_q <= occ_q + CW'(1);
      else if (!push && pop) occ_q <= occ_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      src_q         <= '0;
      run_addr_q    <= '0;
      mem_addr_q    <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      is_mem_q      <= 1'b0;
      fresh_q       <= 1'b0;
      gath_q        <= 1'b0;
      req_hold_q    <= 1'b0;
      done_pushed_q <= 1'b0;
      err_q         <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      fresh_q    <= rf_rd_en && (state_q == S_DFETCH || state_q == S_LFETCH);
      gath_q     <= rf_rd_en && (state_q == S_RFGATH);
      hold_q     <= word;
      req_hold_q <= mem_req && !mem_gnt;
      if (push && !push_last) run_addr_q <= run_addr_q + ADDR_W'(1);
      case (state_q)
        S_IDLE: if (start) begin
          ptr_q         <= start_idx;
          run_addr_q    <= start_out_addr;
          err_q         <= 1'b0;
          done_pushed_q <= 1'b0;
          idle_q        <= 1'b0;
          state_q       <= S_DFETCH;
        end
        S_DFETCH: if (!pause) begin
          ptr_q   <= ptr_q + RF_AW'(1);
          state_q <= S_DDEC;
        end
        S_DDEC: if (!pause) begin
          if (word == '0) state_q <= S_DONE;
          else begin
            case (opc)
              3'b000: if (credit) state_q <= S_DFETCH;
              3'b001: begin
                src_q    <= word[RF_AW-1:0];
                is_mem_q <= 1'b0;
                state_q  <= S_LFETCH;
              end
              3'b010: begin
                mem_addr_q <= ADDR_W'(word[DATA_W-4:0]);
                is_mem_q   <= 1'b1;
                state_q    <= S_LFETCH;
              end
              default: begin
`ifdef DESC_STREAM_ERR_EN
                err_q   <= 1'b1;
                state_q <= S_DONE;
`else
                state_q <= S_DFETCH;
`endif
              end
            endcase
          end
        end
        S_LFETCH: if (!pause) begin
          ptr_q   <= ptr_q + RF_AW'(1);
          state_q <= S_LDEC;
        end
        S_LDEC: if (!pause) begin
          cnt_q <= word[LEN_W-1:0];
          if (word[LEN_W-1:0] == '0) state_q <= S_DFETCH;
          else if (is_mem_q)         state_q <= S_MEMREQ;
          else                       state_q <= S_RFGATH;
        end
        S_RFGATH: if (rf_rd_en) begin
          src_q <= src_q + RF_AW'(1);
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_q <= S_DFETCH;
        end
        // A granted request must follow its data even while paused.
        S_MEMREQ: if (mem_req && mem_gnt) state_q <= S_MEMWAIT;
        S_MEMWAIT: if (mem_rvalid) begin
          mem_addr_q <= mem_addr_q + STRIDE_C;
          cnt_q      <= cnt_q - LEN_W'(1);
          state_q    <= (cnt_q == LEN_W'(1)) ? S_DFETCH : S_MEMREQ;
        end
        S_DONE: begin
          if (push) done_pushed_q <= 1'b1;
          if ((done_pushed_q || err_q) && (occ_q == '0 || (pop && occ_q == CW'(1)))) begin
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_desc_stream_engine.sv
// tb/tb_desc_stream_engine.sv - directed self-checking bench for desc_stream_engine
// Expectations for the illegal-opcode case follow DESC_STREAM_ERR_EN.
module tb_desc_stream_engine;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0, out_ready = 1'b1;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [4:0]  start_idx = '0;
  logic [31:0] start_out_addr = '0;
  logic        idle, rf_rd_en, mem_req, out_valid, out_last, err;
  logic [4:0]  rf_addr;
  logic [31:0] rf_rdata = '0, mem_rdata = '0, mem_addr, out_addr, out_data;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int pause_rd = 0, unstable = 0, gnt_delay = 0, wait_cnt = 0;
  logic        prev_req_wait = 1'b0;
  logic [31:0] prev_maddr = '0;
  logic [31:0] rf [32];
  logic [31:0] cap_a[$], cap_d[$], acc_addr[$];
  logic        cap_l[$];
  int          rd_cyc[$];
  logic [4:0]  rd_addr[$];

  desc_stream_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_idx(start_idx),
    .start_out_addr(start_out_addr), .pause(pause), .idle(idle),
    .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  // MPRF with one-cycle read latency, memory granting after gnt_delay wait cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_rd_en) rf_rdata <= rf[rf_addr];
    if (!rst_n) begin
      mem_gnt <= 1'b0; mem_rvalid <= 1'b0; wait_cnt <= 0;
    end else begin
      mem_rvalid <= mem_req && mem_gnt;
      mem_rdata  <= 32'hC0DE_0000 + mem_addr;
      if (mem_req && mem_gnt) begin
        mem_gnt <= 1'b0; wait_cnt <= 0;
      end else if (mem_req) begin
        if (wait_cnt >= gnt_delay) mem_gnt <= 1'b1;
        else wait_cnt <= wait_cnt + 1;
      end else begin
        mem_gnt <= 1'b0; wait_cnt <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        cap_a.push_back(out_addr); cap_d.push_back(out_data); cap_l.push_back(out_last);
      end
      if (rf_rd_en) begin
        rd_cyc.push_back(cyc); rd_addr.push_back(rf_addr);
        if (pause) pause_rd++;
      end
      if (mem_req && mem_gnt) acc_addr.push_back(mem_addr);
      if (mem_req && prev_req_wait && mem_addr !== prev_maddr) unstable++;
      prev_req_wait = mem_req && !mem_gnt;
      prev_maddr    = mem_addr;
    end
  end

  task automatic run_engine(input logic [4:0] idx, input logic [31:0] oaddr,
                            input int stall_at, input int stall_len,
                            input int pause_at, input int pause_len, output bit timed_out);
    cap_a.delete(); cap_d.delete(); cap_l.delete();
    rd_cyc.delete(); rd_addr.delete(); acc_addr.delete();
    pause_rd = 0; unstable = 0;
    @(posedge clk); #1;
    start_idx = idx; start_out_addr = oaddr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < 300; k++) begin
      out_ready = !(k >= stall_at && k < stall_at + stall_len);
      pause     = (k >= pause_at && k < pause_at + pause_len);
      @(posedge clk); #1;
      if (idle) begin timed_out = 1'b0; break; end
    end
    out_ready = 1'b1; pause = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
    n_cmp++;
    if ({out_valid, rf_rd_en, mem_req, out_last, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {out_valid, rf_rd_en, mem_req, out_last, err});
    end
    n_cmp++;
    if ({out_addr, out_data, mem_addr} !== 96'h0) begin
      n_fail++; $display("FAIL reset_buses: got %h %h %h expected zeros", out_addr, out_data, mem_addr);
    end
  endtask

  task automatic test_literals();
    bit to;
    logic [31:0] ea [2] = '{32'h100, 32'h1F};
    logic [31:0] ed [2] = '{32'hAA, 32'h1};
    logic        el [2] = '{1'b0, 1'b1};
    rf[3] = 32'h0000_00AA; rf[4] = 32'h0;
    run_engine(5'd3, 32'h100, 1000, 0, 1000, 0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL lit_idle: got idle=0 expected 1"); end
    n_cmp++; if (cap_a.size() != 2) begin n_fail++; $display("FAIL lit_count: got %0d expected 2", cap_a.size()); end
    for (int i = 0; i < 2 && i < cap_a.size(); i++) begin
      n_cmp++;
      if (cap_a[i] !== ea[i] || cap_d[i] !== ed[i] || cap_l[i] !== el[i]) begin
        n_fail++; $display("FAIL lit_word%0d: got %h/%h/%b expected %h/%h/%b", i, cap_a[i], cap_d[i], cap_l[i], ea[i], ed[i], el[i]);
      end
    end
  endtask

  task automatic test_rf_gather();
    bit to;
    int j;
    logic [31:0] ea [4] = '{32'h0, 32'h1, 32'h2, 32'h1F};
    logic [31:0] ed [4] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'h1};
    logic        el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    rf[0] = 32'h2000_0010; rf[1] = 32'd3; rf[2] = 32'h0;
    rf[16] = 32'hA0A0_0001; rf[17] = 32'hB0B0_0002; rf[18] = 32'hC0C0_0003;
    run_engine(5'd0, 32'h0, 1000, 0, 1000, 0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL rfg_idle: got idle=0 expected 1"); end
    n_cmp++; if (cap_a.size() != 4) begin n_fail++; $display("FAIL rfg_count: got %0d expected 4", cap_a.size()); end
    for (int i = 0; i < 4 && i < cap_a.size(); i++) begin
      n_cmp++;
      if (cap_a[i] !== ea[i] || cap_d[i] !== ed[i] || cap_l[i] !== el[i]) begin
        n_fail++; $display("FAIL rfg_word%0d: got %h/%h/%b expected %h/%h/%b", i, cap_a[i], cap_d[i], cap_l[i], ea[i], ed[i], el[i]);
      end
    end
    j = -1;
    for (int i = 0; i < rd_addr.size(); i++) if (j < 0 && rd_addr[i] == 5'd16) j = i;
    n_cmp++;
    if (j < 0 || j + 2 >= rd_addr.size()) begin
      n_fail++; $display("FAIL rfg_reads: got %0d reads expected 16,17,18 sequence", rd_addr.size());
    end else if (rd_addr[j+1] !== 5'd17 || rd_addr[j+2] !== 5'd18 || rd_cyc[j+2] - rd_cyc[j] != 2) begin
      n_fail++; $display("FAIL rfg_reads: got %0d,%0d span %0d expected 17,18 span 2", rd_addr[j+1], rd_addr[j+2], rd_cyc[j+2] - rd_cyc[j]);
    end
  endtask

  task automatic test_mem_stall();
    bit to;
    logic [31:0] ea [3] = '{32'h0, 32'h1, 32'h1F};
    logic [31:0] ed [3] = '{32'hC0DE_0200, 32'hC0DE_0204, 32'h1};
    logic        el [3] = '{1'b0, 1'b0, 1'b1};
    rf[0] = 32'h4000_0200; rf[1] = 32'd2; rf[2] = 32'h0;
    gnt_delay = 3;
    run_engine(5'd0, 32'h0, 1000, 0, 1000, 0, to);
    gnt_delay = 0;
    n_cmp++; if (to) begin n_fail++; $display("FAIL mem_idle: got idle=0 expected 1"); end
    n_cmp++; if (cap_a.size() != 3) begin n_fail++; $display("FAIL mem_count: got %0d expected 3", cap_a.size()); end
    for (int i = 0; i < 3 && i < cap_a.size(); i++) begin
      n_cmp++;
      if (cap_a[i] !== ea[i] || cap_d[i] !== ed[i] || cap_l[i] !== el[i]) begin
        n_fail++; $display("FAIL mem_word%0d: got %h/%h/%b expected %h/%h/%b", i, cap_a[i], cap_d[i], cap_l[i], ea[i], ed[i], el[i]);
      end
    end
    n_cmp++; if (acc_addr.size() != 2) begin n_fail++; $display("FAIL mem_reqs: got %0d expected 2", acc_addr.size()); end
    n_cmp++;
    if (acc_addr.size() >= 2 && (acc_addr[0] !== 32'h200 || acc_addr[1] !== 32'h204)) begin
      n_fail++; $display("FAIL mem_addrs: got %h,%h expected 200,204", acc_addr[0], acc_addr[1]);
    end
    n_cmp++; if (unstable != 0) begin n_fail++; $display("FAIL mem_stable: got %0d changes expected 0", unstable); end
  endtask

  task automatic test_backpressure();
    bit to;
    rf[0] = 32'h2000_0008; rf[1] = 32'd4; rf[2] = 32'h0;
    rf[8] = 32'h1111_0008; rf[9] = 32'h2222_0009; rf[10] = 32'h3333_000A; rf[11] = 32'h4444_000B;
    run_engine(5'd0, 32'h40, 6, 5, 1000, 0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL bp_idle: got idle=0 expected 1"); end
    n_cmp++; if (cap_a.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d expected 5", cap_a.size()); end
    for (int i = 0; i < 4 && i < cap_a.size(); i++) begin
      n_cmp++;
      if (cap_a[i] !== 32'h40 + i || cap_d[i] !== rf[8+i] || cap_l[i] !== 1'b0) begin
        n_fail++; $display("FAIL bp_word%0d: got %h/%h expected %h/%h", i, cap_a[i], cap_d[i], 32'h40 + i, rf[8+i]);
      end
    end
    n_cmp++;
    if (cap_a.size() == 5 && (cap_a[4] !== 32'h1F || cap_l[4] !== 1'b1)) begin
      n_fail++; $display("FAIL bp_done: got %h/%b expected 0000001f/1", cap_a[4], cap_l[4]);
    end
  endtask

  task automatic test_pause_wrap();
    bit to;
    logic [31:0] ed [3];
    rf[30] = 32'h3030_3030; rf[31] = 32'h3131_3131;
    rf[0] = 32'h2000_001E; rf[1] = 32'd3; rf[2] = 32'h2000_0005; rf[3] = 32'd0; rf[4] = 32'h0;
    ed = '{32'h3030_3030, 32'h3131_3131, 32'h2000_001E};
    run_engine(5'd0, 32'h0, 1000, 0, 5, 4, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL pw_idle: got idle=0 expected 1"); end
    n_cmp++; if (cap_a.size() != 4) begin n_fail++; $display("FAIL pw_count: got %0d expected 4", cap_a.size()); end
    for (int i = 0; i < 3 && i < cap_a.size(); i++) begin
      n_cmp++;
      if (cap_a[i] !== i || cap_d[i] !== ed[i]) begin
        n_fail++; $display("FAIL pw_word%0d: got %h/%h expected %h/%h", i, cap_a[i], cap_d[i], i, ed[i]);
      end
    end
    n_cmp++; if (pause_rd != 0) begin n_fail++; $display("FAIL pw_pause_reads: got %0d expected 0", pause_rd); end
  endtask

  task automatic test_illegal();
    bit to;
    rf[0] = 32'h6000_0000; rf[1] = 32'h0000_0055; rf[2] = 32'h0;
    run_engine(5'd0, 32'h0, 1000, 0, 1000, 0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL ill_idle: got idle=0 expected 1"); end
`ifdef DESC_STREAM_ERR_EN
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b expected 1", err); end
    n_cmp++; if (cap_a.size() != 0) begin n_fail++; $display("FAIL ill_count: got %0d expected 0", cap_a.size()); end
`else
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err: got %b expected 0", err); end
    n_cmp++; if (cap_a.size() != 2) begin n_fail++; $display("FAIL ill_count: got %0d expected 2", cap_a.size()); end
    n_cmp++;
    if (cap_a.size() == 2 && (cap_d[0] !== 32'h55 || cap_a[1] !== 32'h1F || cap_l[1] !== 1'b1)) begin
      n_fail++; $display("FAIL ill_words: got %h,%h/%b expected 00000055,0000001f/1", cap_d[0], cap_a[1], cap_l[1]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    rf[0] = 32'h4000_0300; rf[1] = 32'd2; rf[2] = 32'h0;
    @(posedge clk); #1;
    start_idx = 5'd0; start_out_addr = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk); #1;
      if (mem_req && mem_gnt) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL rm_grant: got no grant expected one"); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({idle, mem_req, rf_rd_en, out_valid, out_last, err} !== 6'b100000) begin
      n_fail++; $display("FAIL rm_ctrl: got %b expected 100000", {idle, mem_req, rf_rd_en, out_valid, out_last, err});
    end
    n_cmp++;
    if ({out_addr, out_data, mem_addr} !== 96'h0) begin
      n_fail++; $display("FAIL rm_buses: got %h %h %h expected zeros", out_addr, out_data, mem_addr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    test_reset();
    test_literals();
    test_rf_gather();
    test_mem_stall();
    test_backpressure();
    test_pause_wrap();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
